countdown_controller: RTL

//  Sequencing FSM around a loadable N-bit down-counter core.

---
 rtl/countdown_pkg.sv | 12 +
 rtl/down_counter_core.sv | 25 ++
 rtl/countdown_controller.sv | 109 ++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown controller and its counter core.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

  // Prescaler register width.
  // It is wide enough to hold PRESCALE-1 and still works for PRESCALE == 1.
  function automatic int psc_width(input int prescale);
    return $clog2(prescale) + 1;
  endfunction

endpackage

// File: rtl/down_counter_core.sv
// Loadable N-bit down-counter that saturates at zero.
// The counter core has no sequencing logic of its own.
// The controller decides when to load it and when to decrement it.
module down_counter_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         dec_en,
  output logic [N-1:0] count,
  output logic         zero
);

  // Load takes precedence over decrement, and a count of zero is never decremented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= '0;
    else if (load)                     count <= load_value;
    else if (dec_en && count != '0)    count <= count - N'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/countdown_controller.sv
// Sequencing FSM around down_counter_core.
// It turns start/pause/abort levels into counter loads and into decrement enables
// spaced by the prescaler. It also flags expiry with a single-cycle done.
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         auto_reload,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         done
);

  localparam int PW = psc_width(PRESCALE);

  cd_state_t       state, ns;
  logic [PW-1:0]   psc, psc_n;
  logic            ld, dec, zero, tick;
  logic [N-1:0]    ld_val;

  assign tick = (psc == PW'(PRESCALE - 1));

  // Next-state, counter command and prescaler update. A later abort overrides everything.
  always_comb begin
    ns     = state;
    psc_n  = psc;
    ld     = 1'b0;
    dec    = 1'b0;
    ld_val = load_value;
    case (state)
      IDLE: begin
        if (start) begin
          ld    = 1'b1;
          psc_n = '0;
          ns    = (load_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pause) begin
          ns = PAUSE;                 // tick of this cycle is dropped; everything holds
        end else if (tick) begin
          psc_n = '0;
          dec   = !zero;
          if (count == N'(1)) ns = DONE;
        end else begin
          psc_n = psc + PW'(1);
        end
      end
      PAUSE: begin
        if (!pause) ns = RUN;         // prescaler resumes from its frozen phase
      end
      DONE: begin
        if (auto_reload) begin
          ld    = 1'b1;
          psc_n = '0;
          ns    = (load_value == '0) ? DONE : RUN;
        end else begin
          ns = IDLE;
        end
      end
      default: ns = IDLE;
    endcase
    if (abort) begin
      ns     = IDLE;
      ld     = 1'b1;
      ld_val = '0;
      dec    = 1'b0;
      psc_n  = '0;
    end
  end

  // State and prescaler registers.
  // The status outputs are registered from the next state, so they align with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      psc    <= '0;
      busy   <= 1'b0;
      paused <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= ns;
      psc    <= psc_n;
      busy   <= (ns == RUN) || (ns == PAUSE);
      paused <= (ns == PAUSE);
      done   <= (ns == DONE);
    end
  end

  down_counter_core #(.N(N)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .load_value (ld_val),
    .dec_en     (dec),
    .count      (count),
    .zero       (zero)
  );

endmodule
